// File: rtl/fu_matrix_ldst.sv
// Matrix load/store functional unit: latches one issued op, hands it to the scratchpad over a
// valid/ready handshake, waits for completion and pulses done. Supports flush and a timeout flag.
module fu_matrix_ldst #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned MAT_W   = 4,
    parameter int unsigned IMM_W   = 11,
    parameter int unsigned TMO_CYC = 1024
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              mem_type,
    input  logic [MAT_W-1:0]  rd,
    input  logic [WORD_W-1:0] rdat1,
    input  logic [WORD_W-1:0] rdat2,
    input  logic [IMM_W-1:0]  imm,
    input  logic              flush,
    input  logic              sp_ready,
    input  logic              sp_done,
    output logic              busy,
    output logic              done,
    output logic              req_valid,
    output logic [1:0]        ls_out,
    output logic [MAT_W-1:0]  rd_out,
    output logic [IMM_W-1:0]  imm_out,
    output logic [WORD_W-1:0] address,
    output logic [WORD_W-1:0] stride_out,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    localparam logic [WORD_W-1:0] TmoLast = WORD_W'(TMO_CYC - 1);
    localparam logic [WORD_W-1:0] TmoMax  = WORD_W'(TMO_CYC);
    localparam logic [WORD_W-1:0] CntOne  = {{(WORD_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic              mem_type_q, mem_type_d;
    logic [MAT_W-1:0]  rd_q, rd_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] stride_q, stride_d;
    logic [IMM_W-1:0]  imm_q, imm_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              squash_q, squash_d;
    logic              latch;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        squash_d = squash_q;
        latch    = 1'b0;
        unique case (state_q)
            StIdle: begin
                squash_d = 1'b0;
                if (en) begin
                    latch   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (sp_ready) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                if (cnt_q != TmoMax) begin
                    cnt_d = cnt_q + CntOne;
                end
                if (cnt_q >= TmoLast) begin
                    err_d = 1'b1;
                end
                if (flush) begin
                    squash_d = 1'b1;
                end
                // A squashed op still has to drain at the scratchpad, but reports no completion.
                if (sp_done) begin
                    state_d = (squash_q || flush) ? StIdle : StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mem_type_d = mem_type_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        imm_d      = imm_q;
        if (latch) begin
            mem_type_d = mem_type;
            rd_d       = rd;
            addr_d     = rdat1;
            stride_d   = rdat2;
            imm_d      = imm;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= StIdle;
            mem_type_q <= 1'b0;
            rd_q       <= '0;
            addr_q     <= '0;
            stride_q   <= '0;
            imm_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_type_q <= mem_type_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            imm_q      <= imm_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            squash_q   <= squash_d;
        end
    end

    // Outputs decode only flopped state, so nothing combinational reaches them from inputs.
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign req_valid  = (state_q == StReq);
    assign ls_out     = (state_q == StIdle) ? 2'b00 : (mem_type_q ? 2'b10 : 2'b01);
    assign rd_out     = rd_q;
    assign imm_out    = imm_q;
    assign address    = addr_q;
    assign stride_out = stride_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fu_matrix_ldst.sv
// Scoreboard bench for fu_matrix_ldst: stimulus queues expected requests/completions, a negedge
// monitor pops and compares whenever req_valid or done is presented.
module tb_fu_matrix_ldst;

    logic        CLK, nRST, en, mem_type, flush, sp_ready, sp_done;
    logic [3:0]  rd;
    logic [31:0] rdat1, rdat2;
    logic [10:0] imm;
    logic        busy, done, req_valid, err;
    logic [1:0]  ls_out;
    logic [3:0]  rd_out;
    logic [10:0] imm_out;
    logic [31:0] address, stride_out;

    typedef struct packed {
        logic [1:0]  ls;
        logic [3:0]  rd;
        logic [10:0] imm;
        logic [31:0] addr;
        logic [31:0] stride;
    } req_t;

    req_t req_exp_q[$];
    req_t done_exp_q[$];
    int   done_cyc_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    fu_matrix_ldst #(
        .WORD_W (32),
        .MAT_W  (4),
        .IMM_W  (11),
        .TMO_CYC(8)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .en        (en),
        .mem_type  (mem_type),
        .rd        (rd),
        .rdat1     (rdat1),
        .rdat2     (rdat2),
        .imm       (imm),
        .flush     (flush),
        .sp_ready  (sp_ready),
        .sp_done   (sp_done),
        .busy      (busy),
        .done      (done),
        .req_valid (req_valid),
        .ls_out    (ls_out),
        .rd_out    (rd_out),
        .imm_out   (imm_out),
        .address   (address),
        .stride_out(stride_out),
        .err       (err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every presented request / completion must match the head of its queue.
    always @(negedge CLK) begin
        req_t got, e;
        int   ec;
        got = '{ls: ls_out, rd: rd_out, imm: imm_out, addr: address, stride: stride_out};
        if (nRST) begin
            if (en) chk("en_while_busy", busy, 0);
            if (req_valid) begin
                if (req_exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_req: got %0h want none (cycle %0d)", got, cyc);
                end else begin
                    e = req_exp_q.pop_front();
                    chk("req_fields", got, e);
                end
            end
            if (done) begin
                if (done_exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got %0h want none (cycle %0d)", got, cyc);
                end else begin
                    e  = done_exp_q.pop_front();
                    ec = done_cyc_q.pop_front();
                    chk("done_fields", got, e);
                    chk("done_cycle", cyc, ec);
                end
            end
        end
    end

    // Issue one op: en in the next period, sp_ready after `stall` REQ cycles, sp_done in the
    // first WAIT cycle. Returns during the DONE period (done expected en-period + 3 + stall).
    task automatic do_op(input logic m, input logic [3:0] r, input logic [31:0] a,
                         input logic [31:0] s, input logic [10:0] i, input int stall);
        req_t e;
        tick();
        e = '{ls: (m ? 2'b10 : 2'b01), rd: r, imm: i, addr: a, stride: s};
        en = 1'b1; mem_type = m; rd = r; rdat1 = a; rdat2 = s; imm = i; sp_ready = 1'b0;
        for (int k = 0; k <= stall; k++) req_exp_q.push_back(e);
        done_exp_q.push_back(e);
        done_cyc_q.push_back(cyc + 3 + stall);
        tick();
        en = 1'b0; mem_type = ~m; rd = 4'hF; rdat1 = 32'hDEAD_BEEF; rdat2 = 32'hCAFE_F00D;
        imm = 11'h2AA;
        repeat (stall) tick();
        sp_ready = 1'b1;
        tick();
        sp_ready = 1'b0; sp_done = 1'b1;
        tick();
        sp_done = 1'b0;
    endtask

    task automatic start_op(input logic m, input logic [3:0] r, input logic [31:0] a,
                            input logic [31:0] s, input logic [10:0] i);
        req_t e;
        tick();
        e = '{ls: (m ? 2'b10 : 2'b01), rd: r, imm: i, addr: a, stride: s};
        en = 1'b1; mem_type = m; rd = r; rdat1 = a; rdat2 = s; imm = i;
        req_exp_q.push_back(e);
        tick();
        en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0; en = 1'b0; mem_type = 1'b0; rd = '0; rdat1 = '0; rdat2 = '0; imm = '0;
        flush = 1'b0; sp_ready = 1'b0; sp_done = 1'b0;
        @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_done_req", {done, req_valid}, 0);
        chk("rst_ls_err", {ls_out, err}, 0);
        chk("rst_fields", {rd_out, imm_out, address, stride_out}, 0);
        tick();
        nRST = 1'b1;

        // Load, no stall: done three cycles after en.
        do_op(1'b1, 4'd5, 32'h100, 32'h10, 11'h7FF, 0);
        // Store with sp_ready held low for 4 REQ cycles.
        do_op(1'b0, 4'd3, 32'h2000, 32'h4, 11'h123, 4);
        tick();
        @(negedge CLK);
        chk("idle_after_store", {busy, ls_out}, 0);

        // Flush in REQ with sp_ready high in the same cycle.
        start_op(1'b1, 4'd7, 32'h300, 32'h8, 11'h55);
        flush = 1'b1; sp_ready = 1'b1;
        tick();
        flush = 1'b0; sp_ready = 1'b0;
        @(negedge CLK);
        chk("flush_req_busy", busy, 0);
        chk("flush_req_ls", ls_out, 0);
        tick();
        @(negedge CLK);
        chk("flush_req_stay_idle", busy, 0);

        // Flush in WAIT; sp_done two cycles later drains the op with no done.
        start_op(1'b0, 4'd9, 32'h400, 32'h20, 11'h0);
        sp_ready = 1'b1;
        tick();
        sp_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge CLK);
        chk("flush_wait_busy1", {busy, ls_out}, 3'b101);
        tick();
        sp_done = 1'b1;
        @(negedge CLK);
        chk("flush_wait_busy2", busy, 1);
        tick();
        sp_done = 1'b0;
        @(negedge CLK);
        chk("flush_wait_idle", busy, 0);

        // Back-to-back: second en in the cycle right after done.
        do_op(1'b1, 4'd1, 32'h10, 32'h1, 11'h1, 0);
        do_op(1'b0, 4'd2, 32'h20, 32'h2, 11'h2, 1);

        // Timeout with TMO_CYC=8: err rises after the 8th WAIT cycle and sticks.
        start_op(1'b1, 4'd4, 32'h500, 32'h40, 11'h3);
        sp_ready = 1'b1;
        tick();
        sp_ready = 1'b0;
        repeat (7) tick();
        @(negedge CLK);
        chk("tmo_err_before", err, 0);
        tick();
        @(negedge CLK);
        chk("tmo_err_set", {err, busy}, 2'b11);
        repeat (3) tick();
        @(negedge CLK);
        chk("tmo_err_sticky", {err, busy, ls_out}, 4'b1110);
        tick();
        nRST = 1'b0;
        #2;
        chk("rst_mid_wait_ctl", {busy, done, req_valid, err, ls_out}, 0);
        chk("rst_mid_wait_fields", {rd_out, imm_out, address, stride_out}, 0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        @(negedge CLK);
        chk("err_clear_after_rst", {err, busy}, 0);

        // Unit recovers after reset.
        do_op(1'b1, 4'd11, 32'h600, 32'h80, 11'h44, 2);
        tick();
        tick();
        @(negedge CLK);
        chk("req_queue_drained", req_exp_q.size(), 0);
        chk("done_queue_drained", done_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
